mem_commit_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage and upstream of writeback.
- Holds one instruction under a valid/allow-in handshake and commits its store to data SRAM exactly once.
- Resolves the instruction's exception flags by priority into LoongArch ecode/esubcode/badv, and raises the pipeline flush for exceptions and ERTN.
- Drives a registered payload to writeback, plus a register-forwarding port back to decode.

---
 rtl/mem_commit_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_commit_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_commit_stage.sv
// Memory/commit pipeline stage: holds one instruction, commits its store once on fire,
// resolves exception flags into LoongArch ecode/badv and raises exception/ERTN flushes.
module mem_commit_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int unsigned ECODE_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               es_to_ms_valid,
  output logic               ms_allow_in,
  input  logic               ws_allow_in,
  input  logic [31:0]        es_pc,
  input  logic [3:0]         es_rf_we,
  input  logic [4:0]         es_rf_waddr,
  input  logic [31:0]        es_rf_wdata,
  input  logic [3:0]         es_csr_we,
  input  logic [13:0]        es_csr_num,
  input  logic [31:0]        es_csr_wdata,
  input  logic [31:0]        es_csr_wmask,
  input  logic [31:0]        es_sram_addr,
  input  logic [31:0]        es_sram_wdata,
  input  logic [3:0]         es_store_strb,
  input  logic               es_ertn,
  input  logic [6:0]         es_excp,
  output logic [3:0]         data_sram_we,
  output logic [31:0]        data_sram_addr,
  output logic [31:0]        data_sram_wdata,
  output logic               ms_fwd_valid,
  output logic [4:0]         ms_fwd_waddr,
  output logic [31:0]        ms_fwd_wdata,
  output logic               ms_to_ws_valid,
  output logic [31:0]        ws_pc,
  output logic [3:0]         ws_rf_we,
  output logic [4:0]         ws_rf_waddr,
  output logic [31:0]        ws_rf_wdata,
  output logic [3:0]         ws_csr_we,
  output logic [13:0]        ws_csr_num,
  output logic [31:0]        ws_csr_wdata,
  output logic [31:0]        ws_csr_wmask,
  output logic               excp_flush,
  output logic               ertn_flush,
  output logic [ECODE_W-1:0] excp_ecode,
  output logic [8:0]         excp_esubcode,
  output logic [31:0]        excp_era,
  output logic [31:0]        excp_badv,
  output logic               excp_badv_we
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  localparam logic [ECODE_W-1:0] EcodeInt  = ECODE_W'(6'h00);
  localparam logic [ECODE_W-1:0] EcodeAdef = ECODE_W'(6'h08);
  localparam logic [ECODE_W-1:0] EcodeIne  = ECODE_W'(6'h0D);
  localparam logic [ECODE_W-1:0] EcodeIpe  = ECODE_W'(6'h0E);
  localparam logic [ECODE_W-1:0] EcodeSys  = ECODE_W'(6'h0B);
  localparam logic [ECODE_W-1:0] EcodeBrk  = ECODE_W'(6'h0C);
  localparam logic [ECODE_W-1:0] EcodeAle  = ECODE_W'(6'h09);

  state_e state_q, state_d;
  logic        ms_valid_q, ms_valid_d;
  logic [31:0] pc_q, pc_d, rf_wdata_q, rf_wdata_d, csr_wdata_q, csr_wdata_d;
  logic [31:0] csr_wmask_q, csr_wmask_d, addr_q, addr_d, st_data_q, st_data_d;
  logic [3:0]  rf_we_q, rf_we_d, csr_we_q, csr_we_d, strb_q, strb_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [13:0] csr_num_q, csr_num_d;
  logic        ertn_q, ertn_d;
  logic [6:0]  excp_q, excp_d;

  logic        ws_valid_q, ws_valid_d;
  logic [31:0] ws_pc_q, ws_pc_d, ws_rf_wdata_q, ws_rf_wdata_d;
  logic [31:0] ws_csr_wdata_q, ws_csr_wdata_d, ws_csr_wmask_q, ws_csr_wmask_d;
  logic [3:0]  ws_rf_we_q, ws_rf_we_d, ws_csr_we_q, ws_csr_we_d;
  logic [4:0]  ws_rf_waddr_q, ws_rf_waddr_d;
  logic [13:0] ws_csr_num_q, ws_csr_num_d;

  logic fire, excp_any, flush_any, accept;

  always_comb begin
    ms_allow_in = (state_q == StFlush) | ~ms_valid_q | ws_allow_in;
    fire        = ms_valid_q & ws_allow_in;
    excp_any    = |excp_q;
    excp_flush  = fire & excp_any;
    ertn_flush  = fire & ertn_q & ~excp_any;
    flush_any   = excp_flush | ertn_flush;
    // Nothing enters while flushing; the younger instruction is discarded.
    accept      = es_to_ms_valid & ms_allow_in & (state_q == StRun) & ~flush_any;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush_any) state_d = StFlush;
      StFlush: state_d = StRun;
      default: state_d = StRun;
    endcase

    ms_valid_d = ms_valid_q;
    if ((state_q == StFlush) || flush_any) ms_valid_d = 1'b0;
    else if (ms_allow_in)                  ms_valid_d = es_to_ms_valid;

    pc_d        = accept ? es_pc         : pc_q;
    rf_we_d     = accept ? es_rf_we      : rf_we_q;
    rf_waddr_d  = accept ? es_rf_waddr   : rf_waddr_q;
    rf_wdata_d  = accept ? es_rf_wdata   : rf_wdata_q;
    csr_we_d    = accept ? es_csr_we     : csr_we_q;
    csr_num_d   = accept ? es_csr_num    : csr_num_q;
    csr_wdata_d = accept ? es_csr_wdata  : csr_wdata_q;
    csr_wmask_d = accept ? es_csr_wmask  : csr_wmask_q;
    addr_d      = accept ? es_sram_addr  : addr_q;
    st_data_d   = accept ? es_sram_wdata : st_data_q;
    strb_d      = accept ? es_store_strb : strb_q;
    ertn_d      = accept ? es_ertn       : ertn_q;
    excp_d      = accept ? es_excp       : excp_q;
  end

  always_comb begin
    ws_valid_d     = ws_valid_q;
    ws_pc_d        = ws_pc_q;
    ws_rf_we_d     = ws_rf_we_q;
    ws_rf_waddr_d  = ws_rf_waddr_q;
    ws_rf_wdata_d  = ws_rf_wdata_q;
    ws_csr_we_d    = ws_csr_we_q;
    ws_csr_num_d   = ws_csr_num_q;
    ws_csr_wdata_d = ws_csr_wdata_q;
    ws_csr_wmask_d = ws_csr_wmask_q;
    if (fire) begin
      // ERTN still reaches writeback (with no writes); an exception does not.
      ws_valid_d     = ~excp_any;
      ws_pc_d        = pc_q;
      ws_rf_we_d     = (excp_any | ertn_q) ? 4'h0 : rf_we_q;
      ws_rf_waddr_d  = rf_waddr_q;
      ws_rf_wdata_d  = rf_wdata_q;
      ws_csr_we_d    = (excp_any | ertn_q) ? 4'h0 : csr_we_q;
      ws_csr_num_d   = csr_num_q;
      ws_csr_wdata_d = csr_wdata_q;
      ws_csr_wmask_d = csr_wmask_q;
    end else if (ws_allow_in) begin
      ws_valid_d = 1'b0;
    end
  end

  always_comb begin
    excp_ecode    = '0;
    excp_esubcode = '0;
    excp_era      = '0;
    excp_badv     = '0;
    excp_badv_we  = 1'b0;
    if (excp_flush) begin
      if      (excp_q[6]) excp_ecode = EcodeInt;
      else if (excp_q[5]) excp_ecode = EcodeAdef;
      else if (excp_q[4]) excp_ecode = EcodeIne;
      else if (excp_q[3]) excp_ecode = EcodeIpe;
      else if (excp_q[2]) excp_ecode = EcodeSys;
      else if (excp_q[1]) excp_ecode = EcodeBrk;
      else                excp_ecode = EcodeAle;
      excp_era     = pc_q;
      excp_badv_we = excp_q[5] | excp_q[0];
      if      (excp_q[5]) excp_badv = pc_q;
      else if (excp_q[0]) excp_badv = addr_q;
    end
  end

  always_comb begin
    data_sram_we    = (fire & ~excp_any & ~ertn_q) ? strb_q : 4'h0;
    data_sram_addr  = ms_valid_q ? addr_q : 32'h0;
    data_sram_wdata = ms_valid_q ? st_data_q : 32'h0;
    ms_fwd_valid    = ms_valid_q & (|rf_we_q) & (rf_waddr_q != 5'd0) & ~excp_any;
    ms_fwd_waddr    = ms_valid_q ? rf_waddr_q : 5'd0;
    ms_fwd_wdata    = ms_valid_q ? rf_wdata_q : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      ms_valid_q     <= 1'b0;
      pc_q           <= '0;
      rf_we_q        <= '0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      csr_we_q       <= '0;
      csr_num_q      <= '0;
      csr_wdata_q    <= '0;
      csr_wmask_q    <= '0;
      addr_q         <= '0;
      st_data_q      <= '0;
      strb_q         <= '0;
      ertn_q         <= 1'b0;
      excp_q         <= '0;
      ws_valid_q     <= 1'b0;
      ws_pc_q        <= RESET_PC;
      ws_rf_we_q     <= '0;
      ws_rf_waddr_q  <= '0;
      ws_rf_wdata_q  <= '0;
      ws_csr_we_q    <= '0;
      ws_csr_num_q   <= '0;
      ws_csr_wdata_q <= '0;
      ws_csr_wmask_q <= '0;
    end else begin
      state_q        <= state_d;
      ms_valid_q     <= ms_valid_d;
      pc_q           <= pc_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      csr_we_q       <= csr_we_d;
      csr_num_q      <= csr_num_d;
      csr_wdata_q    <= csr_wdata_d;
      csr_wmask_q    <= csr_wmask_d;
      addr_q         <= addr_d;
      st_data_q      <= st_data_d;
      strb_q         <= strb_d;
      ertn_q         <= ertn_d;
      excp_q         <= excp_d;
      ws_valid_q     <= ws_valid_d;
      ws_pc_q        <= ws_pc_d;
      ws_rf_we_q     <= ws_rf_we_d;
      ws_rf_waddr_q  <= ws_rf_waddr_d;
      ws_rf_wdata_q  <= ws_rf_wdata_d;
      ws_csr_we_q    <= ws_csr_we_d;
      ws_csr_num_q   <= ws_csr_num_d;
      ws_csr_wdata_q <= ws_csr_wdata_d;
      ws_csr_wmask_q <= ws_csr_wmask_d;
    end
  end

  assign ms_to_ws_valid = ws_valid_q;
  assign ws_pc          = ws_pc_q;
  assign ws_rf_we       = ws_rf_we_q;
  assign ws_rf_waddr    = ws_rf_waddr_q;
  assign ws_rf_wdata    = ws_rf_wdata_q;
  assign ws_csr_we      = ws_csr_we_q;
  assign ws_csr_num     = ws_csr_num_q;
  assign ws_csr_wdata   = ws_csr_wdata_q;
  assign ws_csr_wmask   = ws_csr_wmask_q;

endmodule

// File: tb/tb_mem_commit_stage.sv
// Directed bench for mem_commit_stage: a vector table of single instructions plus
// hand-written stall, flush-drop and reset-mid-store sequences.
module tb_mem_commit_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid, ms_allow_in, ws_allow_in;
  logic [31:0] es_pc, es_rf_wdata, es_csr_wdata, es_csr_wmask, es_sram_addr, es_sram_wdata;
  logic [3:0]  es_rf_we, es_csr_we, es_store_strb;
  logic [4:0]  es_rf_waddr;
  logic [13:0] es_csr_num;
  logic        es_ertn;
  logic [6:0]  es_excp;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_waddr;
  logic [31:0] ms_fwd_wdata;
  logic        ms_to_ws_valid;
  logic [31:0] ws_pc, ws_rf_wdata, ws_csr_wdata, ws_csr_wmask;
  logic [3:0]  ws_rf_we, ws_csr_we;
  logic [4:0]  ws_rf_waddr;
  logic [13:0] ws_csr_num;
  logic        excp_flush, ertn_flush;
  logic [5:0]  excp_ecode;
  logic [8:0]  excp_esubcode;
  logic [31:0] excp_era, excp_badv;
  logic        excp_badv_we;

  int n_checks = 0;
  int n_fail   = 0;

  mem_commit_stage dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allow_in(ms_allow_in),
    .ws_allow_in(ws_allow_in), .es_pc(es_pc), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
    .es_rf_wdata(es_rf_wdata), .es_csr_we(es_csr_we), .es_csr_num(es_csr_num),
    .es_csr_wdata(es_csr_wdata), .es_csr_wmask(es_csr_wmask), .es_sram_addr(es_sram_addr),
    .es_sram_wdata(es_sram_wdata), .es_store_strb(es_store_strb), .es_ertn(es_ertn),
    .es_excp(es_excp), .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .ms_fwd_valid(ms_fwd_valid),
    .ms_fwd_waddr(ms_fwd_waddr), .ms_fwd_wdata(ms_fwd_wdata),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_pc(ws_pc), .ws_rf_we(ws_rf_we),
    .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata), .ws_csr_we(ws_csr_we),
    .ws_csr_num(ws_csr_num), .ws_csr_wdata(ws_csr_wdata), .ws_csr_wmask(ws_csr_wmask),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .excp_ecode(excp_ecode),
    .excp_esubcode(excp_esubcode), .excp_era(excp_era), .excp_badv(excp_badv),
    .excp_badv_we(excp_badv_we)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [6:0]  excp;
    logic        ertn;
    logic [3:0]  strb;
    logic [3:0]  rf_we;
    logic [4:0]  waddr;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  csr_we;
    logic [3:0]  e_sram_we;
    logic        e_excp;
    logic        e_ertn;
    logic [5:0]  e_ecode;
    logic        e_badv_we;
    logic [31:0] e_badv;
    logic        e_fwd;
    logic [3:0]  e_ws_rf_we;
    logic [3:0]  e_ws_csr_we;
    logic        e_ws_valid;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [6:0] excp, input logic ertn,
                       input logic [3:0] strb, input logic [3:0] rf_we, input logic [4:0] waddr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] csr_we);
    es_to_ms_valid = 1'b1;
    es_pc          = pc;
    es_excp        = excp;
    es_ertn        = ertn;
    es_store_strb  = strb;
    es_rf_we       = rf_we;
    es_rf_waddr    = waddr;
    es_rf_wdata    = wdata;
    es_sram_addr   = addr;
    es_sram_wdata  = wdata;
    es_csr_we      = csr_we;
    es_csr_num     = 14'h6;
    es_csr_wdata   = 32'h0;
    es_csr_wmask   = 32'hffff_ffff;
  endtask

  initial begin
    // excp ertn strb rf_we waddr pc addr wdata csr_we | sram exf erf ecode bwe badv fwd wsrf wscsr wsv
    vecs[0]  = '{7'h00, 0, 4'hF, 4'h0, 5'd0, 32'h1c000000, 32'h1c0, 32'hDEADBEEF, 4'h0,
                 4'hF, 0, 0, 6'h00, 0, 32'h0, 0, 4'h0, 4'h0, 1};
    vecs[1]  = '{7'h01, 0, 4'h0, 4'hF, 5'd4, 32'h1c000100, 32'h1c002, 32'h0, 4'h0,
                 4'h0, 1, 0, 6'h09, 1, 32'h1c002, 0, 4'h0, 4'h0, 0};
    vecs[2]  = '{7'h44, 0, 4'h0, 4'hF, 5'd3, 32'h1c000200, 32'h100, 32'h55, 4'h0,
                 4'h0, 1, 0, 6'h00, 0, 32'h0, 0, 4'h0, 4'h0, 0};
    vecs[3]  = '{7'h21, 0, 4'h0, 4'h0, 5'd0, 32'h1c000301, 32'h203, 32'h0, 4'h0,
                 4'h0, 1, 0, 6'h08, 1, 32'h1c000301, 0, 4'h0, 4'h0, 0};
    vecs[4]  = '{7'h00, 0, 4'h0, 4'hF, 5'd5, 32'h1c000400, 32'h0, 32'h1234, 4'h0,
                 4'h0, 0, 0, 6'h00, 0, 32'h0, 1, 4'hF, 4'h0, 1};
    vecs[5]  = '{7'h00, 0, 4'h0, 4'hF, 5'd0, 32'h1c000404, 32'h0, 32'h77, 4'h0,
                 4'h0, 0, 0, 6'h00, 0, 32'h0, 0, 4'hF, 4'h0, 1};
    vecs[6]  = '{7'h00, 1, 4'h0, 4'h0, 5'd0, 32'h1c000500, 32'h0, 32'h0, 4'h1,
                 4'h0, 0, 1, 6'h00, 0, 32'h0, 0, 4'h0, 4'h0, 1};
    vecs[7]  = '{7'h10, 0, 4'hF, 4'h0, 5'd0, 32'h1c000600, 32'h40, 32'hAA, 4'h0,
                 4'h0, 1, 0, 6'h0D, 0, 32'h0, 0, 4'h0, 4'h0, 0};
    vecs[8]  = '{7'h08, 0, 4'h0, 4'h0, 5'd0, 32'h1c000700, 32'h0, 32'h0, 4'h0,
                 4'h0, 1, 0, 6'h0E, 0, 32'h0, 0, 4'h0, 4'h0, 0};
    vecs[9]  = '{7'h02, 0, 4'h0, 4'h0, 5'd0, 32'h1c000800, 32'h0, 32'h0, 4'h0,
                 4'h0, 1, 0, 6'h0C, 0, 32'h0, 0, 4'h0, 4'h0, 0};
    vecs[10] = '{7'h04, 1, 4'h0, 4'h0, 5'd0, 32'h1c000900, 32'h0, 32'h0, 4'h1,
                 4'h0, 1, 0, 6'h0B, 0, 32'h0, 0, 4'h0, 4'h0, 0};
    vecs[11] = '{7'h00, 0, 4'h4, 4'hF, 5'd7, 32'h1c000a00, 32'h88, 32'h00ab0000, 4'h0,
                 4'h4, 0, 0, 6'h00, 0, 32'h0, 1, 4'hF, 4'h0, 1};

    reset = 1'b1;
    ws_allow_in = 1'b1;
    drive(32'h0, 7'h0, 1'b0, 4'h0, 4'h0, 5'd0, 32'h0, 32'h0, 4'h0);
    es_to_ms_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("reset ms_to_ws_valid", {31'b0, ms_to_ws_valid}, 32'h0);
    check("reset ws_pc", ws_pc, 32'h1c000000);
    check("reset ms_allow_in", {31'b0, ms_allow_in}, 32'h1);
    check("reset data_sram_we", {28'b0, data_sram_we}, 32'h0);
    check("reset ws_rf_we", {28'b0, ws_rf_we}, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].pc, vecs[i].excp, vecs[i].ertn, vecs[i].strb, vecs[i].rf_we,
            vecs[i].waddr, vecs[i].addr, vecs[i].wdata, vecs[i].csr_we);
      step();
      es_to_ms_valid = 1'b0;
      #1;
      check($sformatf("v%0d data_sram_we", i), {28'b0, data_sram_we}, {28'b0, vecs[i].e_sram_we});
      check($sformatf("v%0d excp_flush", i), {31'b0, excp_flush}, {31'b0, vecs[i].e_excp});
      check($sformatf("v%0d ertn_flush", i), {31'b0, ertn_flush}, {31'b0, vecs[i].e_ertn});
      check($sformatf("v%0d excp_ecode", i), {26'b0, excp_ecode}, {26'b0, vecs[i].e_ecode});
      check($sformatf("v%0d excp_badv_we", i), {31'b0, excp_badv_we},
            {31'b0, vecs[i].e_badv_we});
      check($sformatf("v%0d excp_badv", i), excp_badv, vecs[i].e_badv);
      check($sformatf("v%0d excp_era", i), excp_era, vecs[i].e_excp ? vecs[i].pc : 32'h0);
      check($sformatf("v%0d ms_fwd_valid", i), {31'b0, ms_fwd_valid}, {31'b0, vecs[i].e_fwd});
      check($sformatf("v%0d ms_fwd_wdata", i), ms_fwd_wdata, vecs[i].wdata);
      check($sformatf("v%0d ms_fwd_waddr", i), {27'b0, ms_fwd_waddr}, {27'b0, vecs[i].waddr});
      step();
      check($sformatf("v%0d ms_to_ws_valid", i), {31'b0, ms_to_ws_valid},
            {31'b0, vecs[i].e_ws_valid});
      check($sformatf("v%0d ws_rf_we", i), {28'b0, ws_rf_we}, {28'b0, vecs[i].e_ws_rf_we});
      check($sformatf("v%0d ws_csr_we", i), {28'b0, ws_csr_we}, {28'b0, vecs[i].e_ws_csr_we});
      check($sformatf("v%0d ws_pc", i), ws_pc, vecs[i].pc);
      check($sformatf("v%0d store once", i), {28'b0, data_sram_we}, 32'h0);
      step();
    end

    // Stall: a held store must not be written until writeback accepts.
    ws_allow_in = 1'b0;
    drive(32'h1c001000, 7'h0, 1'b0, 4'h3, 4'h0, 5'd0, 32'h300, 32'h0000beef, 4'h0);
    step();
    es_to_ms_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d data_sram_we", k), {28'b0, data_sram_we}, 32'h0);
      check($sformatf("stall%0d ms_allow_in", k), {31'b0, ms_allow_in}, 32'h0);
      step();
    end
    ws_allow_in = 1'b1;
    #1;
    check("stall release data_sram_we", {28'b0, data_sram_we}, 32'h3);
    check("stall release ms_allow_in", {31'b0, ms_allow_in}, 32'h1);
    step();
    check("stall after data_sram_we", {28'b0, data_sram_we}, 32'h0);
    check("stall after ms_to_ws_valid", {31'b0, ms_to_ws_valid}, 32'h1);
    check("stall after ws_pc", ws_pc, 32'h1c001000);
    step();

    // ALE followed by a younger store: the younger one is dropped, then re-accepted.
    drive(32'h1c000100, 7'h01, 1'b0, 4'h0, 4'hF, 5'd4, 32'h1c002, 32'h0, 4'h0);
    step();
    drive(32'h1c002000, 7'h0, 1'b0, 4'hF, 4'h0, 5'd0, 32'h500, 32'h11223344, 4'h0);
    #1;
    check("ale excp_flush", {31'b0, excp_flush}, 32'h1);
    check("ale data_sram_we", {28'b0, data_sram_we}, 32'h0);
    step();
    check("flush ms_allow_in", {31'b0, ms_allow_in}, 32'h1);
    check("flush dropped data_sram_we", {28'b0, data_sram_we}, 32'h0);
    check("flush ms_fwd_valid", {31'b0, ms_fwd_valid}, 32'h0);
    check("flush ms_to_ws_valid", {31'b0, ms_to_ws_valid}, 32'h0);
    step();
    check("flush+1 still empty", {28'b0, data_sram_we}, 32'h0);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    check("reaccept data_sram_we", {28'b0, data_sram_we}, 32'hF);
    check("reaccept data_sram_addr", data_sram_addr, 32'h500);
    check("reaccept data_sram_wdata", data_sram_wdata, 32'h11223344);
    step();
    check("reaccept ws_pc", ws_pc, 32'h1c002000);
    check("reaccept ms_to_ws_valid", {31'b0, ms_to_ws_valid}, 32'h1);
    step();

    // Reset while a store is held under a stall.
    ws_allow_in = 1'b0;
    drive(32'h1c003000, 7'h0, 1'b0, 4'hF, 4'hF, 5'd9, 32'h600, 32'h99, 4'h0);
    step();
    es_to_ms_valid = 1'b0;
    check("pre-reset data_sram_we", {28'b0, data_sram_we}, 32'h0);
    check("pre-reset ms_fwd_valid", {31'b0, ms_fwd_valid}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ws_allow_in = 1'b1;
    #1;
    check("post-reset data_sram_we", {28'b0, data_sram_we}, 32'h0);
    check("post-reset ms_fwd_valid", {31'b0, ms_fwd_valid}, 32'h0);
    check("post-reset ws_pc", ws_pc, 32'h1c000000);
    check("post-reset ms_to_ws_valid", {31'b0, ms_to_ws_valid}, 32'h0);
    step();
    check("post-reset+1 data_sram_we", {28'b0, data_sram_we}, 32'h0);
    check("post-reset+1 ms_to_ws_valid", {31'b0, ms_to_ws_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
